// File: rtl/parzen_pkg.sv
// parzen_pkg: shared types, widths and helpers for the Parzen window consumer.
//   - DEF_*      : default configuration of the block
//   - COEFF_BITS : coefficient width for the default configuration
//   - PROD_BITS  : stage-1 product width for the default configuration
//   - state_e    : frame FSM states
//   - round_sat  : round-half-up, arithmetic shift and saturate of a product
package parzen_pkg;

    localparam int unsigned DEF_WINDOW_SIZE_POW2 = 10;
    localparam int unsigned DEF_COEFF_FRAC_BITS  = 16;
    localparam int unsigned DEF_SAMPLE_BITS      = 16;

    localparam int unsigned COEFF_BITS = DEF_WINDOW_SIZE_POW2 + DEF_COEFF_FRAC_BITS;
    localparam int unsigned PROD_BITS  = DEF_SAMPLE_BITS + COEFF_BITS + 1;

    // Products of any configuration are sign-extended into this container.
    localparam int unsigned ACC_BITS = 64;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    // Returns the saturated sample in the low sample_bits of the container;
    // the caller truncates to its own sample width.
    function automatic logic signed [ACC_BITS-1:0] round_sat(
        input logic signed [ACC_BITS-1:0] prod,
        input int unsigned                frac_bits,
        input int unsigned                sample_bits
    );
        logic signed [ACC_BITS-1:0] one;
        logic signed [ACC_BITS-1:0] half;
        logic signed [ACC_BITS-1:0] hi;
        logic signed [ACC_BITS-1:0] lo;
        logic signed [ACC_BITS-1:0] r;
        one  = 64'sd1;
        half = one <<< (frac_bits - 1);
        hi   = (one <<< (sample_bits - 1)) - one;
        lo   = -(one <<< (sample_bits - 1));
        r    = (prod + half) >>> frac_bits;
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/parzen_join2.sv
// parzen_join2: joins two valid/ready streams under a shared advance enable.
//   a_valid/b_valid : producer valids
//   adv             : downstream can accept (pipeline not stalled)
//   a_ready/b_ready : each side is accepted only together with the other
//   fire            : a pair is consumed this cycle
module parzen_join2 (
    input  logic a_valid,
    input  logic b_valid,
    input  logic adv,
    output logic a_ready,
    output logic b_ready,
    output logic fire
);

    assign a_ready = b_valid && adv;
    assign b_ready = a_valid && adv;
    assign fire    = a_valid && b_valid && adv;

endmodule

// File: rtl/parzen_window_apply.sv
// parzen_window_apply: multiplies each signed sample by its unsigned Parzen
// window coefficient, rounds/saturates back to sample width and frames output.
//   clk, rst                       : clock, synchronous active-high reset
//   s_data/s_valid/s_last/s_ready  : sample stream in
//   c_coeff/c_valid/c_ready        : coefficient stream in, UQ(INT).(FRAC)
//   m_data/m_valid/m_last/m_ready  : windowed sample stream out
//   frame_done                     : pulse after an m_last beat transfers
//   frame_err                      : pulse after a frame-length mismatch
module parzen_window_apply
    import parzen_pkg::*;
#(
    parameter int unsigned WINDOW_SIZE_POW2 = DEF_WINDOW_SIZE_POW2,
    parameter int unsigned COEFF_FRAC_BITS  = DEF_COEFF_FRAC_BITS,
    parameter int unsigned COEFF_INT_BITS   = WINDOW_SIZE_POW2,
    parameter int unsigned SAMPLE_BITS      = DEF_SAMPLE_BITS
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [SAMPLE_BITS-1:0]                  s_data,
    input  logic                                    s_valid,
    input  logic                                    s_last,
    output logic                                    s_ready,
    input  logic [COEFF_INT_BITS+COEFF_FRAC_BITS-1:0] c_coeff,
    input  logic                                    c_valid,
    output logic                                    c_ready,
    output logic [SAMPLE_BITS-1:0]                  m_data,
    output logic                                    m_valid,
    output logic                                    m_last,
    input  logic                                    m_ready,
    output logic                                    frame_done,
    output logic                                    frame_err
);

    localparam int unsigned CW = COEFF_INT_BITS + COEFF_FRAC_BITS;
    localparam int unsigned PW = SAMPLE_BITS + CW + 1;
    localparam int unsigned IW = WINDOW_SIZE_POW2;

    logic adv;
    logic fire;

    state_e                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [IW-1:0]           cur_idx;
    logic                    at_end;
    logic                    tag_last;
    logic                    err_q, err_d;

    logic                    v1_q, v1_d;
    logic signed [PW-1:0]    prod_q, prod_d;
    logic                    last1_q, last1_d;
    logic signed [PW-1:0]    s_ext, c_ext;

    logic                    m_valid_q, m_valid_d;
    logic [SAMPLE_BITS-1:0]  m_data_q, m_data_d;
    logic                    m_last_q, m_last_d;
    logic                    done_q, done_d;

    // Whole pipeline stalls as one unit while an output beat is refused.
    assign adv = !(m_valid_q && !m_ready);

    parzen_join2 u_join (
        .a_valid (s_valid),
        .b_valid (c_valid),
        .adv     (adv),
        .a_ready (s_ready),
        .b_ready (c_ready),
        .fire    (fire)
    );

    // Frame FSM: a beat closes the frame either at the last index or when the
    // source marks s_last; any disagreement between the two is an error.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        err_d    = 1'b0;
        tag_last = 1'b0;
        cur_idx  = (state_q == IDLE) ? '0 : idx_q;
        at_end   = &cur_idx;
        if (fire) begin
            if (at_end || s_last) begin
                tag_last = 1'b1;
                idx_d    = '0;
                state_d  = IDLE;
                err_d    = (at_end != s_last);
            end else begin
                idx_d    = cur_idx + 1'b1;
                state_d  = RUN;
            end
        end
    end

    // Two-stage datapath: stage 1 multiplies, stage 2 rounds and saturates.
    always_comb begin
        s_ext     = PW'($signed(s_data));
        c_ext     = PW'({1'b0, c_coeff});
        v1_d      = v1_q;
        prod_d    = prod_q;
        last1_d   = last1_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        if (adv) begin
            v1_d      = fire;
            last1_d   = fire && tag_last;
            if (fire) begin
                prod_d = s_ext * c_ext;
            end
            m_valid_d = v1_q;
            m_last_d  = v1_q && last1_q;
            if (v1_q) begin
                m_data_d = SAMPLE_BITS'(round_sat(ACC_BITS'(prod_q), COEFF_FRAC_BITS, SAMPLE_BITS));
            end
        end
        done_d = m_valid_q && m_ready && m_last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            err_q     <= 1'b0;
            v1_q      <= 1'b0;
            prod_q    <= '0;
            last1_q   <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            v1_q      <= v1_d;
            prod_q    <= prod_d;
            last1_q   <= last1_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            done_q    <= done_d;
        end
    end

    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign m_last     = m_last_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_parzen_window_apply.sv
// tb_parzen_window_apply: randomized and directed stimulus for
// parzen_window_apply (8-sample frames) checked against a scoreboard whose
// expected values come from plain integer arithmetic on the window rules.
module tb_parzen_window_apply;

    localparam int unsigned WSP2 = 3;
    localparam int unsigned FRAC = 16;
    localparam int unsigned SB   = 16;
    localparam int unsigned CBW  = WSP2 + FRAC;

    logic                 clk;
    logic                 rst;
    logic signed [SB-1:0] s_data;
    logic                 s_valid;
    logic                 s_last;
    logic                 s_ready;
    logic [CBW-1:0]       c_coeff;
    logic                 c_valid;
    logic                 c_ready;
    logic [SB-1:0]        m_data;
    logic                 m_valid;
    logic                 m_last;
    logic                 m_ready;
    logic                 frame_done;
    logic                 frame_err;

    parzen_window_apply #(
        .WINDOW_SIZE_POW2 (WSP2),
        .COEFF_FRAC_BITS  (FRAC),
        .COEFF_INT_BITS   (WSP2),
        .SAMPLE_BITS      (SB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .c_coeff    (c_coeff),
        .c_valid    (c_valid),
        .c_ready    (c_ready),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint data;
        bit     last;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    int   n_err    = 0;
    int   model_idx = 0;
    bit   err_pend  = 0;
    bit   done_pend = 0;
    bit   rand_ready  = 0;
    bit   ready_force = 1;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Windowed value: round(s * c / 2^FRAC) with ties toward +inf, clamped.
    function automatic longint ref_win(input longint s, input longint c);
        longint p;
        longint r;
        p = s * c + 32768;
        if (p >= 0) r = p / 65536;
        else        r = -((-p + 65535) / 65536);
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    always @(posedge clk) begin
        #1;
        if (rand_ready) m_ready = ($urandom % 4) != 0;
        else            m_ready = ready_force;
    end

    // Scoreboard / frame model, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            model_idx = 0;
            err_pend  = 0;
            done_pend = 0;
        end else begin
            check("frame_err", frame_err, err_pend);
            check("frame_done", frame_done, done_pend);
            if (frame_done) n_done++;
            if (frame_err)  n_err++;
            err_pend  = 0;
            done_pend = 0;
            if (!c_valid) check("s_ready_without_coeff", s_ready, 0);
            if (!s_valid) check("c_ready_without_sample", c_ready, 0);
            if (m_valid) begin
                if (q.size() == 0) begin
                    check("spurious_m_valid", m_valid, 0);
                end else begin
                    check("m_data", $signed(m_data), q[0].data);
                    check("m_last", m_last, q[0].last);
                    if (!m_ready) begin
                        check("s_ready_stall", s_ready, 0);
                        check("c_ready_stall", c_ready, 0);
                    end else begin
                        done_pend = q[0].last;
                        void'(q.pop_front());
                    end
                end
            end
            if (s_valid && c_valid && s_ready && c_ready) begin
                exp_t e;
                bit   at_end;
                at_end = (model_idx == 7);
                e.data = ref_win(longint'(s_data), longint'(c_coeff));
                e.last = s_last || at_end;
                err_pend = (s_last != at_end);
                model_idx = e.last ? 0 : model_idx + 1;
                q.push_back(e);
            end
        end
    end

    // Entered and left at posedge+1.
    task automatic send(input logic signed [SB-1:0] s, input logic [CBW-1:0] c, input bit last, input bit skew);
        bit got;
        s_data  = s;
        c_coeff = c;
        s_last  = last;
        if (skew) begin
            if ($urandom % 2) s_valid = 1'b1;
            else              c_valid = 1'b1;
            repeat (1 + $urandom % 2) @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        c_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_ready && c_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        c_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        check("drain_empty", q.size(), 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit last_at_end);
        for (int i = 0; i < n; i++)
            send(16'($urandom), CBW'($urandom_range(0, (1 << CBW) - 1)), last_at_end && (i == n - 1), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, e0, pos;
        rst = 1'b1; s_data = '0; s_valid = 0; s_last = 0; c_coeff = '0; c_valid = 0; m_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_m_data", m_data, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_c_ready", c_ready, 0);
        @(posedge clk);
        #1;

        // Unity gain, two-cycle latency, then back-to-back.
        send(1234, 'h10000, 0, 0);
        check("latency_edge1_m_valid", m_valid, 0);
        @(posedge clk);
        #1;
        check("latency_edge2_m_valid", m_valid, 1);
        check("latency_edge2_m_data", $signed(m_data), 1234);
        send(1234, 'h10000, 0, 0);
        send(-1, 'h10000, 0, 0);
        drain();

        // Rounding at 0.5 and saturation at 2.0.
        send(-3, 'h08000, 0, 0);
        send(3, 'h08000, 0, 0);
        send(1, 'h08000, 0, 0);
        send(32767, 'h20000, 0, 0);
        send(-32768, 'h20000, 0, 0);
        drain();

        // Backpressure: five stalled cycles inside a 16-beat stream.
        fork
            for (int i = 0; i < 16; i++)
                send(16'($urandom), CBW'($urandom_range(0, (1 << CBW) - 1)), 0, 0);
            begin
                repeat (6) @(posedge clk);
                ready_force = 0;
                repeat (5) @(posedge clk);
                ready_force = 1;
            end
        join
        drain();
        do_reset();

        // Framing.
        d0 = n_done; e0 = n_err;
        send_frame(8, 1);
        drain();
        check("frame8_done_count", n_done - d0, 1);
        check("frame8_err_count", n_err - e0, 0);
        d0 = n_done; e0 = n_err;
        send_frame(5, 1);
        drain();
        check("early_last_done_count", n_done - d0, 1);
        check("early_last_err_count", n_err - e0, 1);
        d0 = n_done; e0 = n_err;
        send_frame(8, 1);
        drain();
        check("restart_done_count", n_done - d0, 1);
        check("restart_err_count", n_err - e0, 0);
        d0 = n_done; e0 = n_err;
        send_frame(8, 0);
        drain();
        check("missing_last_done_count", n_done - d0, 1);
        check("missing_last_err_count", n_err - e0, 1);

        // Reset at idx 4 with two beats in flight.
        send_frame(5, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("m_valid_after_rst", m_valid, 0);
        end
        @(posedge clk);
        #1;
        d0 = n_done; e0 = n_err;
        send_frame(8, 1);
        drain();
        check("post_rst_done_count", n_done - d0, 1);
        check("post_rst_err_count", n_err - e0, 0);

        // Randomized traffic with random backpressure and occasional bad framing.
        rand_ready = 1;
        pos = 0;
        for (int i = 0; i < 200; i++) begin
            bit lst;
            lst = (pos == 7);
            if ($urandom % 20 == 0) lst = !lst;
            send(16'($urandom), CBW'($urandom_range(0, (1 << CBW) - 1)), lst, ($urandom % 4) == 0);
            pos = (lst || pos == 7) ? 0 : pos + 1;
        end
        rand_ready = 0;
        ready_force = 1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/parzen_window_apply.md
# parzen_window_apply

Consumer side of the Parzen window coefficient stream. The block joins a signed sample stream with the coefficient stream produced by the Parzen window generator and multiplies each sample by its coefficient, one pair per beat. It rounds and saturates each product back to sample width and emits windowed samples with frame delimiting. It sits between the sample source and the downstream FFT/accumulator.

## Interface
- WINDOW_SIZE_POW2, 10, frame length is FRAME_LEN = 2**WINDOW_SIZE_POW2 samples
- COEFF_FRAC_BITS, 16, coefficient fractional bits
- COEFF_INT_BITS, WINDOW_SIZE_POW2, coefficient integer bits; coefficient is unsigned Q(COEFF_INT_BITS).(COEFF_FRAC_BITS)
- SAMPLE_BITS, 16, signed two's-complement sample width, in and out

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_data  in  SAMPLE_BITS  input sample
- s_valid  in  1  sample valid
- s_last  in  1  source marks final sample of frame
- s_ready  out  1  sample accepted when s_valid && s_ready
- c_coeff  in  COEFF_INT_BITS+COEFF_FRAC_BITS  window coefficient
- c_valid  in  1  coefficient valid
- c_ready  out  1  coefficient accepted when c_valid && c_ready
- m_data  out  SAMPLE_BITS  windowed sample
- m_valid  out  1  output valid
- m_last  out  1  final sample of frame
- m_ready  in  1  downstream accept
- frame_done  out  1  one-cycle pulse when an m_last beat transfers
- frame_err  out  1  one-cycle pulse on frame-length mismatch

## Operation
- Join: fire = s_valid && c_valid && adv. s_ready = c_valid && adv. c_ready = s_valid && adv. A sample is never consumed without its coefficient, and vice versa.
- adv = !(m_valid && !m_ready). The whole pipeline stalls as one unit.
- Stage 1 (registered): prod = signed(s_data) * signed({1'b0, c_coeff}). Width is SAMPLE_BITS+COEFF_INT_BITS+COEFF_FRAC_BITS+1. Index and last tag travel alongside.
- Stage 2 (registered output):
  - Round half up: add 2**(COEFF_FRAC_BITS-1), then arithmetic shift right by COEFF_FRAC_BITS.
  - Saturate to [-2**(SAMPLE_BITS-1), 2**(SAMPLE_BITS-1)-1].
- Frame counter idx, 0..FRAME_LEN-1, increments on fire. m_last is tagged when idx == FRAME_LEN-1. idx wraps to 0 after that beat.
- FSM:
  - IDLE: no frame in progress, idx = 0. First fire goes to RUN, or straight back to IDLE if FRAME_LEN == 1.
  - RUN: stays in RUN while idx < FRAME_LEN-1. The fire at idx == FRAME_LEN-1 returns to IDLE.
- Mismatch handling:
  - s_last at fire with idx != FRAME_LEN-1: pulse frame_err, tag that beat m_last, force idx to 0, go to IDLE.
  - fire at idx == FRAME_LEN-1 without s_last: pulse frame_err; the beat is still tagged m_last.
  - frame_err asserts the cycle after the offending fire.
- frame_done pulses the cycle after m_valid && m_ready && m_last.

## Timing
- Latency: 2 cycles from fire to m_valid with no stall. Throughput is 1 beat/cycle while m_ready is held high.
- When stalled, m_data, m_valid and m_last are held stable, and s_ready and c_ready are low.
- Values on all outputs after reset:
  - m_data = 0, m_valid = 0, m_last = 0
  - frame_done = 0, frame_err = 0
  - s_ready = 0, c_ready = 0
  - idx = 0, FSM in IDLE
- rst mid-frame: in-flight beats are dropped with no output. The next fire after reset is idx 0.
- Simultaneous m_valid && m_ready with a new fire: stage 2 reloads the same cycle, so there is no bubble.
- s_valid without c_valid, or the reverse: nothing is consumed and nothing is dropped.

## Structure
- Package parzen_pkg:
  - Coefficient and product width localparams: COEFF_BITS, PROD_BITS.
  - Function round_sat(prod) -> SAMPLE_BITS.
  - FSM enum typedef {IDLE, RUN}.
- One natural sub-module, parzen_join2: two-stream valid/ready join with a shared advance input. The product pipeline and the frame FSM stay in the top module.

## Test plan
- Unity: coeff 0x0_10000 (1.0) with samples 1234, -1 -> outputs 1234, -1 after 2 cycles, back-to-back.
- Rounding: coeff 0x0_08000 (0.5) with samples -3, 3, 1 -> outputs -1, 2, 1.
- Saturation: coeff 2.0 with sample 32767 -> 32767; with sample -32768 -> -32768.
- Backpressure: stream 16 beats, drop m_ready for 5 cycles mid-stream -> output sequence identical to the no-stall case, m_data held during the stall, no beat lost or duplicated.
- Framing with WINDOW_SIZE_POW2=3: 8 beats with s_last on the 8th -> m_last and frame_done on beat 8. Then s_last on the 5th beat -> frame_err pulse, m_last on beat 5, next frame restarts at idx 0.
- Reset at idx 4 with 2 beats in flight -> no m_valid after reset, and the next frame's m_last arrives exactly on its 8th beat.
